chacha_host_io: RTL and testbench
=================================

# chacha_host_io

Byte-serial host interface for the ChaCha block engine, sitting between the TinyTapeout top-level pins and the ChaCha core. Accepts slow, asynchronous host commands on an 8-bit data bus with a strobe. It assembles the 64-byte input state, launches the core, captures the 512-bit keystream block and streams it back one byte at a time. One 64-byte buffer serves both input staging and result readout.

## Interface
Parameters:
- none; sizes come from `chacha_pkg` (`BLOCK_BYTES`=64, `WORD_W`=32).

Ports:
- `clk`  in  1  system clock; one clock domain, all state on rising edge.
- `rst`  in  1  reset, asynchronous and active-high; clears all state immediately.
- `host_data`  in  8  byte for LOAD; must be stable while `host_strobe` is high.
- `host_cmd`  in  2  command: 00 ABORT, 01 LOAD, 10 START, 11 READ; must be stable while `host_strobe` is high.
- `host_strobe`  in  1  asynchronous command strobe; one command per rising edge.
- `out_data`  out  8  `buffer[ptr]` in OUT state, else 8'h00.
- `out_valid`  out  1  high in OUT state.
- `busy`  out  1  high in RUN state.
- `byte_idx`  out  6  current buffer pointer.
- `core_state`  out  512  buffer flattened; word w at [32w+31:32w].
- `core_start`  out  1  one-cycle pulse that launches the core.
- `core_done`  in  1  one-cycle pulse from the core; result valid the same cycle.
- `core_result`  in  512  keystream block, same word layout as `core_state`.

## Operation
- Byte order is little-endian (RFC 8439). Buffer byte i maps to word i/4, bits [8*(i%4)+7 : 8*(i%4)].
- Strobe path: 3-flop chain s1←strobe, s2←s1, s3←s2. `fire` = s2 & ~s3. `host_cmd` and `host_data` are sampled at the edge where `fire` is high.
- State machine is IDLE / RUN / OUT.
- IDLE:
  - LOAD: `buffer[ptr]` ← `host_data`; ptr increments and wraps 63→0.
  - START: `core_start`=1 for exactly one cycle; ptr←0; go to RUN.
  - READ: ignored.
- RUN:
  - `core_done`: buffer ← `core_result`; ptr←0; go to OUT.
  - LOAD, START, READ: ignored.
- OUT:
  - READ: ptr increments. A READ at ptr=63 wraps ptr to 0 and returns to IDLE.
  - LOAD, START: ignored.
- ABORT, in any state: go to IDLE, ptr←0; buffer unchanged.
- `core_done` in IDLE or OUT is ignored.
- Simultaneous ABORT `fire` and `core_done` in RUN: ABORT wins and the result is discarded.
- Reset values: state IDLE, ptr 0, buffer all zero, s1–s3 0. Outputs at reset: `out_data`=0, `out_valid`=0, `busy`=0, `byte_idx`=0, `core_start`=0, `core_state`=0.

## Timing
- Strobe seen high at edge E1 → command executes at edge E3. This gives 2 cycles of sync latency plus the action edge.
- Strobe must stay high ≥3 cycles and low ≥3 cycles. A strobe held high for N≥3 cycles executes exactly one command.
- START executes at edge E: `core_start` is high for the cycle after E and `busy` is high from E.
- `core_done` sampled at edge D: `out_valid` is high and `out_data`=`buffer[0]` from D.
- `out_data` is combinational from registered ptr/buffer. It updates the cycle after READ executes.
- `core_state` is stable throughout RUN; the core may sample it at any point during RUN.

## Structure
- `chacha_pkg` holds:
  - the command enum (`CMD_ABORT`, `CMD_LOAD`, `CMD_START`, `CMD_READ`);
  - the state enum (`ST_IDLE`, `ST_RUN`, `ST_OUT`);
  - `BLOCK_BYTES` and `WORD_W`.
- Sub-module `chacha_strobe_sync` contains the 3-flop synchronizer and rising-edge detector, with output `fire`. It is reusable for other host strobes.
- The rest is a single FSM, a 6-bit pointer and a 64×8 buffer, all in this block.

## Test plan
- Reset while idle → all outputs 0. Assert `rst` mid-OUT → `out_valid`, `out_data` and `byte_idx` drop to 0 without waiting for a clock edge.
- LOAD bytes 0x00..0x3F, then START → `core_state[31:0]`=32'h03020100 and `core_state[511:480]`=32'h3F3E3D3C. `core_start` pulses exactly one cycle; `busy`=1.
- `core_done` with word0=32'hDEADBEEF → `out_data` reads 0xEF, then after successive READs 0xBE, 0xAD, 0xDE. After the 64th READ: `out_valid`=0, state IDLE, `byte_idx`=0.
- 65 LOADs (0x00..0x40) → `buffer[0]`=0x40, `buffer[1]`=0x01, `byte_idx`=1. A strobe held 10 cycles → exactly one LOAD.
- In RUN, issue LOAD 0xAA → buffer unchanged, `busy` stays 1. Then ABORT → IDLE; a later `core_done` is ignored and `out_valid` stays 0.
- ABORT `fire` on the same edge as `core_done` in RUN → state IDLE and buffer still holds the pre-RUN input.

Source files
------------

// File: rtl/chacha_pkg.sv
// chacha_pkg: shared sizes, host command codes and host-interface state encoding
package chacha_pkg;
   localparam int BLOCK_BYTES = 64;
   localparam int WORD_W = 32;
   typedef enum logic [1:0] {
      CMD_ABORT = 2'b00,
      CMD_LOAD  = 2'b01,
      CMD_START = 2'b10,
      CMD_READ  = 2'b11
   } cmd_e;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OUT  = 2'd2
   } state_e;
endpackage

// File: rtl/chacha_strobe_sync.sv
// chacha_strobe_sync: synchronizes an asynchronous host strobe and flags its rising edge
module chacha_strobe_sync (
   input  logic clk,
   input  logic rst,
   input  logic strobe,
   output logic fire
);
   logic s1, s2, s3;
   // two flops resolve metastability, the third remembers the previous level for edge detect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= strobe;
         s2 <= s1;
         s3 <= s2;
      end
   end
   assign fire = s2 & ~s3;
endmodule

// File: rtl/chacha_host_io.sv
// chacha_host_io: byte-serial host loader/reader around the ChaCha block core
module chacha_host_io
   import chacha_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   host_data,
   input  logic [1:0]   host_cmd,
   input  logic         host_strobe,
   output logic [7:0]   out_data,
   output logic         out_valid,
   output logic         busy,
   output logic [5:0]   byte_idx,
   output logic [511:0] core_state,
   output logic         core_start,
   input  logic         core_done,
   input  logic [511:0] core_result
);
   state_e     state;
   logic [5:0] ptr;
   logic [7:0] buffer [BLOCK_BYTES];
   logic       fire, start_q;
   cmd_e       cmd;
   logic       do_abort, do_load, do_start, do_read, do_done;
   chacha_strobe_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .strobe (host_strobe),
      .fire   (fire)
   );
   assign cmd      = cmd_e'(host_cmd);
   assign do_abort = fire && cmd == CMD_ABORT;
   assign do_load  = fire && cmd == CMD_LOAD  && state == ST_IDLE;
   assign do_start = fire && cmd == CMD_START && state == ST_IDLE;
   assign do_read  = fire && cmd == CMD_READ  && state == ST_OUT;
   assign do_done  = core_done && state == ST_RUN && !do_abort;
   // command FSM and shared pointer; abort outranks a coincident core_done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         ptr     <= 6'd0;
         start_q <= 1'b0;
      end else begin
         start_q <= do_start;
         if (do_abort) begin
            state <= ST_IDLE;
            ptr   <= 6'd0;
         end else if (do_start) begin
            state <= ST_RUN;
            ptr   <= 6'd0;
         end else if (do_done) begin
            state <= ST_OUT;
            ptr   <= 6'd0;
         end else if (do_load) begin
            ptr <= ptr + 6'd1;
         end else if (do_read) begin
            ptr <= ptr + 6'd1;
            if (ptr == 6'(BLOCK_BYTES - 1)) state <= ST_IDLE;
         end
      end
   end
   // single buffer: host bytes in while idle, keystream block captured on completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BLOCK_BYTES; i++) buffer[i] <= 8'h00;
      end else if (do_done) begin
         for (int i = 0; i < BLOCK_BYTES; i++) buffer[i] <= core_result[8*i +: 8];
      end else if (do_load) begin
         buffer[ptr] <= host_data;
      end
   end
   for (genvar g = 0; g < BLOCK_BYTES; g++) begin : g_flat
      assign core_state[8*g +: 8] = buffer[g];
   end
   assign out_valid  = state == ST_OUT;
   assign busy       = state == ST_RUN;
   assign byte_idx   = ptr;
   assign out_data   = out_valid ? buffer[ptr] : 8'h00;
   assign core_start = start_q;
endmodule

// File: tb/tb_chacha_host_io.sv
// tb_chacha_host_io: directed checks of load, start, readout, abort and reset behaviour
module tb_chacha_host_io;
   import chacha_pkg::*;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [7:0]   host_data = 8'h00;
   logic [1:0]   host_cmd = 2'b00;
   logic         host_strobe = 1'b0;
   logic [7:0]   out_data;
   logic         out_valid, busy, core_start;
   logic [5:0]   byte_idx;
   logic [511:0] core_state;
   logic         core_done = 1'b0;
   logic [511:0] core_result = '0;
   int n_chk = 0;
   int n_pass = 0;
   int n_start = 0;
   logic [511:0] res;
   chacha_host_io dut (
      .clk         (clk),
      .rst         (rst),
      .host_data   (host_data),
      .host_cmd    (host_cmd),
      .host_strobe (host_strobe),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .busy        (busy),
      .byte_idx    (byte_idx),
      .core_state  (core_state),
      .core_start  (core_start),
      .core_done   (core_done),
      .core_result (core_result)
   );
   always #5 clk = ~clk;
   // count cycles in which the launch pulse is asserted
   always @(posedge clk) if (core_start) n_start++;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   task automatic send(input cmd_e c, input logic [7:0] d, input int hi);
      @(negedge clk);
      host_cmd = c;
      host_data = d;
      host_strobe = 1'b1;
      repeat (hi) @(negedge clk);
      host_strobe = 1'b0;
      repeat (4) @(negedge clk);
   endtask
   task automatic done_pulse(input logic [511:0] r);
      @(negedge clk);
      core_result = r;
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      @(negedge clk);
   endtask
   initial begin
      res = '0;
      res[31:0] = 32'hDEADBEEF;
      res[511:480] = 32'hCAFEF00D;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_data", {24'h0, out_data}, 32'h0);
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_byte_idx", {26'h0, byte_idx}, 32'h0);
      chk("rst_core_start", {31'h0, core_start}, 32'h0);
      chk("rst_core_state", {31'h0, |core_state}, 32'h0);
      for (int i = 0; i < 64; i++) send(CMD_LOAD, 8'(i), 3);
      chk("load64_idx_wrap", {26'h0, byte_idx}, 32'h0);
      n_start = 0;
      send(CMD_START, 8'h00, 3);
      chk("start_pulse_cnt", n_start, 32'd1);
      chk("start_pulse_low", {31'h0, core_start}, 32'h0);
      chk("start_busy", {31'h0, busy}, 32'h1);
      chk("state_word0", core_state[31:0], 32'h03020100);
      chk("state_word15", core_state[511:480], 32'h3F3E3D3C);
      done_pulse(res);
      chk("done_valid", {31'h0, out_valid}, 32'h1);
      chk("done_busy", {31'h0, busy}, 32'h0);
      chk("rd_byte0", {24'h0, out_data}, 32'hEF);
      send(CMD_READ, 8'h00, 3);
      chk("rd_byte1", {24'h0, out_data}, 32'hBE);
      send(CMD_READ, 8'h00, 3);
      chk("rd_byte2", {24'h0, out_data}, 32'hAD);
      send(CMD_READ, 8'h00, 3);
      chk("rd_byte3", {24'h0, out_data}, 32'hDE);
      chk("rd_idx3", {26'h0, byte_idx}, 32'd3);
      for (int i = 3; i < 63; i++) send(CMD_READ, 8'h00, 3);
      chk("rd_byte63", {24'h0, out_data}, 32'hCA);
      chk("rd_valid63", {31'h0, out_valid}, 32'h1);
      send(CMD_READ, 8'h00, 3);
      chk("rd_end_valid", {31'h0, out_valid}, 32'h0);
      chk("rd_end_idx", {26'h0, byte_idx}, 32'h0);
      chk("rd_end_data", {24'h0, out_data}, 32'h0);
      for (int i = 0; i < 65; i++) send(CMD_LOAD, 8'(i), 3);
      chk("load65_b0", {24'h0, core_state[7:0]}, 32'h40);
      chk("load65_b1", {24'h0, core_state[15:8]}, 32'h01);
      chk("load65_idx", {26'h0, byte_idx}, 32'd1);
      send(CMD_LOAD, 8'h77, 10);
      chk("long_strobe_idx", {26'h0, byte_idx}, 32'd2);
      chk("long_strobe_word0", core_state[31:0], 32'h03027740);
      send(CMD_START, 8'h00, 3);
      send(CMD_LOAD, 8'hAA, 3);
      chk("run_load_word0", core_state[31:0], 32'h03027740);
      chk("run_load_busy", {31'h0, busy}, 32'h1);
      chk("run_load_idx", {26'h0, byte_idx}, 32'h0);
      send(CMD_ABORT, 8'h00, 3);
      chk("abort_busy", {31'h0, busy}, 32'h0);
      done_pulse(res);
      chk("idle_done_valid", {31'h0, out_valid}, 32'h0);
      chk("idle_done_word0", core_state[31:0], 32'h03027740);
      send(CMD_START, 8'h00, 3);
      chk("run2_busy", {31'h0, busy}, 32'h1);
      @(negedge clk);
      host_cmd = CMD_ABORT;
      host_strobe = 1'b1;
      @(negedge clk);
      @(negedge clk);
      core_result = res;
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      host_strobe = 1'b0;
      repeat (4) @(negedge clk);
      chk("race_busy", {31'h0, busy}, 32'h0);
      chk("race_valid", {31'h0, out_valid}, 32'h0);
      chk("race_word0", core_state[31:0], 32'h03027740);
      send(CMD_START, 8'h00, 3);
      done_pulse(res);
      send(CMD_READ, 8'h00, 3);
      chk("pre_rst_data", {24'h0, out_data}, 32'hBE);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_valid", {31'h0, out_valid}, 32'h0);
      chk("async_rst_data", {24'h0, out_data}, 32'h0);
      chk("async_rst_idx", {26'h0, byte_idx}, 32'h0);
      chk("async_rst_state", {31'h0, |core_state}, 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
